// File: rtl/bpred_pkg.sv
// Shared definitions for the branch predictor.
// Counter encodings and saturating helpers.
package bpred_pkg;

  localparam int CTR_W = 2;

  localparam logic [CTR_W-1:0] SNT = 2'b00;
  localparam logic [CTR_W-1:0] WNT = 2'b01;
  localparam logic [CTR_W-1:0] WT  = 2'b10;
  localparam logic [CTR_W-1:0] ST  = 2'b11;

  function automatic logic [CTR_W-1:0] ctr_inc(
    input logic [CTR_W-1:0] c
  );
    return (c == ST) ? ST : c + 2'b01;
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(
    input logic [CTR_W-1:0] c
  );
    return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/bpred_stats.sv
// Prediction statistics: registered pulses
// and saturating counters with clear.
module bpred_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_acc,
  input  logic             i_ok,
  input  logic             i_clr,
  output logic             o_inc_br,
  output logic             o_inc_hit,
  output logic             o_inc_mis,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_mis_cnt
);

  logic             r_br_p;
  logic             r_hit_p;
  logic             r_mis_p;
  logic [CNT_W-1:0] r_br;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_mis;
  logic             w_hit;
  logic             w_mis;

  assign w_hit = i_acc & i_ok;
  assign w_mis = i_acc & ~i_ok;

  // One-cycle pulses following each accepted update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_p  <= 1'b0;
      r_hit_p <= 1'b0;
      r_mis_p <= 1'b0;
    end else begin
      r_br_p  <= i_acc;
      r_hit_p <= w_hit;
      r_mis_p <= w_mis;
    end
  end

  // Saturating counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br  <= '0;
      r_hit <= '0;
      r_mis <= '0;
    end else if (i_clr) begin
      r_br  <= '0;
      r_hit <= '0;
      r_mis <= '0;
    end else begin
      if (i_acc && !(&r_br))  r_br  <= r_br + 1'b1;
      if (w_hit && !(&r_hit)) r_hit <= r_hit + 1'b1;
      if (w_mis && !(&r_mis)) r_mis <= r_mis + 1'b1;
    end
  end

  assign o_inc_br  = r_br_p;
  assign o_inc_hit = r_hit_p;
  assign o_inc_mis = r_mis_p;
  assign o_br_cnt  = r_br;
  assign o_hit_cnt = r_hit;
  assign o_mis_cnt = r_mis;

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped BTB with 2-bit direction counters.
// Combinational lookup, trained at the EX stage.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              IDX_W    = 4,
  parameter int              CNT_W    = 16,
  parameter logic [CTR_W-1:0] INIT_CTR = WT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  output logic              hit,
  output logic [ADDR_W-1:0] target_pc,
  input  logic              stall,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_hit,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              inc_br_cnt,
  output logic              inc_hit_cnt,
  output logic              inc_mispr_cnt,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  mispr_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [ADDR_W-1:0] r_tgt [DEPTH];
  logic [CTR_W-1:0] r_ctr [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_match;
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_umatch;
  logic             w_acc;
  logic             w_ok;
  logic             w_alloc;

  assign w_idx   = pc[IDX_W-1:0];
  assign w_tag   = pc[ADDR_W-1:IDX_W];
  assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign hit       = rst_n & en & w_match & r_ctr[w_idx][1];
  assign target_pc = w_match ? r_tgt[w_idx] : '0;

  assign w_uidx   = upd_pc[IDX_W-1:0];
  assign w_utag   = upd_pc[ADDR_W-1:IDX_W];
  assign w_umatch = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_acc    = upd_valid & ~stall;
  assign w_alloc  = w_acc & upd_taken & ~w_umatch;

  assign w_ok = (upd_pred_hit == upd_taken) &
                (~upd_taken | (upd_pred_target == upd_target));

  // Valid bits and direction counters; flush drops the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= SNT;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_acc) begin
      if (upd_taken) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= w_umatch ? ctr_inc(r_ctr[w_uidx])
                                    : INIT_CTR;
      end else if (w_umatch) begin
        r_ctr[w_uidx] <= ctr_dec(r_ctr[w_uidx]);
      end
    end
  end

  // Tag and target payload, gated only by valid
  always_ff @(posedge clk) begin
    if (!flush && w_acc && upd_taken) begin
      r_tgt[w_uidx] <= upd_target;
      if (w_alloc) r_tag[w_uidx] <= w_utag;
    end
  end

  bpred_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_acc     (w_acc),
    .i_ok      (w_ok),
    .i_clr     (cnt_clr),
    .o_inc_br  (inc_br_cnt),
    .o_inc_hit (inc_hit_cnt),
    .o_inc_mis (inc_mispr_cnt),
    .o_br_cnt  (br_cnt),
    .o_hit_cnt (hit_cnt),
    .o_mis_cnt (mispr_cnt)
  );

endmodule

// File: tb/tb_bpred_btb.sv
// Self-checking bench for bpred_btb.
// Directed steps plus random traffic vs a table model.
module tb_bpred_btb;

  localparam int AW = 16;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int NE = 16;
  localparam int CMAX = 15;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] pc;
  logic          hit;
  logic [AW-1:0] target_pc;
  logic          stall;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic          upd_taken;
  logic [AW-1:0] upd_target;
  logic          upd_pred_hit;
  logic [AW-1:0] upd_pred_target;
  logic          flush;
  logic          cnt_clr;
  logic          inc_br_cnt;
  logic          inc_hit_cnt;
  logic          inc_mispr_cnt;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] mispr_cnt;

  bpred_btb #(
    .ADDR_W(AW), .IDX_W(IW), .CNT_W(CW), .INIT_CTR(2'b10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc),
    .hit(hit), .target_pc(target_pc), .stall(stall),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_hit(upd_pred_hit),
    .upd_pred_target(upd_pred_target),
    .flush(flush), .cnt_clr(cnt_clr),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt),
    .inc_mispr_cnt(inc_mispr_cnt), .br_cnt(br_cnt),
    .hit_cnt(hit_cnt), .mispr_cnt(mispr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: entries keyed by index, counters as integers
  bit m_v[NE];
  int m_tag[NE];
  int m_tgt[NE];
  int m_ctr[NE];
  int m_br, m_hit, m_mis;
  bit p_br, p_hit, p_mis;

  task automatic chk(string t, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_v[i] = 0;
      m_ctr[i] = 0;
    end
    m_br = 0; m_hit = 0; m_mis = 0;
    p_br = 0; p_hit = 0; p_mis = 0;
  endtask

  function automatic bit m_match(int a);
    return m_v[a % NE] && m_tag[a % NE] == a / NE;
  endfunction

  function automatic bit m_hitf(bit e, int a);
    return e && m_match(a) && m_ctr[a % NE] >= 2;
  endfunction

  function automatic int m_tgtf(int a);
    return m_match(a) ? m_tgt[a % NE] : 0;
  endfunction

  task automatic m_edge();
    bit acc, ok;
    int ix, a;
    a   = upd_pc;
    ix  = a % NE;
    acc = upd_valid && !stall;
    ok  = (upd_pred_hit == upd_taken) &&
          (!upd_taken || upd_pred_target == upd_target);
    if (flush) begin
      for (int i = 0; i < NE; i++) m_v[i] = 0;
    end else if (acc) begin
      if (upd_taken) begin
        if (m_match(a)) begin
          m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
        end else begin
          m_v[ix] = 1;
          m_tag[ix] = a / NE;
          m_ctr[ix] = 2;
        end
        m_tgt[ix] = upd_target;
      end else if (m_match(a)) begin
        m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
      end
    end
    p_br = acc;
    p_hit = acc && ok;
    p_mis = acc && !ok;
    if (cnt_clr) begin
      m_br = 0; m_hit = 0; m_mis = 0;
    end else begin
      if (p_br && m_br < CMAX) m_br++;
      if (p_hit && m_hit < CMAX) m_hit++;
      if (p_mis && m_mis < CMAX) m_mis++;
    end
  endtask

  task automatic chk_stats(string t);
    chk({t, "_pbr"}, inc_br_cnt, p_br);
    chk({t, "_phit"}, inc_hit_cnt, p_hit);
    chk({t, "_pmis"}, inc_mispr_cnt, p_mis);
    chk({t, "_br"}, br_cnt, m_br);
    chk({t, "_hitc"}, hit_cnt, m_hit);
    chk({t, "_misc"}, mispr_cnt, m_mis);
  endtask

  // one clock cycle; entered and left on a falling edge
  task automatic cyc(
    string t, bit e, int p, bit uv, int upc, bit tk,
    int ut, bit ph, int pt,
    bit st = 0, bit fl = 0, bit cl = 0
  );
    en = e; pc = p[AW-1:0]; upd_valid = uv;
    upd_pc = upc[AW-1:0]; upd_taken = tk;
    upd_target = ut[AW-1:0]; upd_pred_hit = ph;
    upd_pred_target = pt[AW-1:0];
    stall = st; flush = fl; cnt_clr = cl;
    #1;
    chk({t, "_hit"}, hit, m_hitf(e, p));
    chk({t, "_tpc"}, target_pc, m_tgtf(p));
    @(posedge clk);
    m_edge();
    #1;
    chk_stats(t);
    @(negedge clk);
  endtask

  task automatic idle(string t, int p);
    cyc(t, 1, p, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int a, tg;
    bit tk, ph;
    m_reset();
    rst_n = 0; en = 1; pc = 16'h0013; stall = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_hit = 0;
    upd_pred_target = 0; flush = 0; cnt_clr = 0;
    #12;
    chk("rst_hit", hit, 0);
    chk("rst_br", br_cnt, 0);
    chk("rst_mis", mispr_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // allocation on first taken update
    cyc("t1a", 1, 'h13, 1, 'h13, 1, 'h40, 0, 0);
    chk("t1_pmis", inc_mispr_cnt, 1);
    idle("t1b", 'h13);
    chk("t1_hitnow", hit, 1);
    chk("t1_tgt", target_pc, 16'h0040);

    // strengthen, then weaken to the floor
    cyc("t2a", 1, 'h13, 1, 'h13, 1, 'h40, 1, 'h40);
    cyc("t2b", 1, 'h13, 1, 'h13, 1, 'h40, 1, 'h40);
    for (int i = 0; i < 4; i++)
      cyc("t2n", 1, 'h13, 1, 'h13, 0, 0, i < 2, 'h40);
    idle("t2z", 'h13);
    chk("t2_tpc", target_pc, 16'h0040);

    // aliasing on index 3
    cyc("t3a", 1, 'h13, 1, 'h23, 1, 'h100, 0, 0);
    idle("t3b", 'h13);
    idle("t3c", 'h23);
    chk("t3_tgt", target_pc, 16'h0100);

    // same-cycle lookup/update, then stalled update
    cyc("t4a", 1, 'h35, 1, 'h35, 1, 'h200, 0, 0);
    idle("t4b", 'h35);
    cyc("t4c", 1, 'h35, 1, 'h45, 1, 'h300, 0, 0, 1);
    idle("t4d", 'h45);

    // wrong target; prediction disabled while training
    cyc("t5a", 1, 'h23, 1, 'h23, 1, 'h44, 1, 'h40);
    idle("t5b", 'h23);
    chk("t5_tgt", target_pc, 16'h0044);
    cyc("t5c", 0, 'h23, 1, 'h23, 1, 'h44, 0, 0);
    cyc("t5d", 0, 'h23, 0, 0, 0, 0, 0, 0);

    // counter saturation, clear, flush
    for (int i = 0; i < 17; i++)
      cyc("t6s", 1, 'h23, 1, 'h23, 1, 'h44, 1, 'h44);
    chk("t6_sat", hit_cnt, 4'hF);
    cyc("t6c", 1, 'h23, 1, 'h23, 1, 'h44, 1, 'h44, 0, 0, 1);
    chk("t6_clr", br_cnt, 0);
    cyc("t6f", 1, 'h23, 1, 'h13, 1, 'h50, 0, 0, 0, 1);
    idle("t6g", 'h23);
    idle("t6h", 'h13);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a  = $urandom_range(0, 63);
      tg = $urandom_range(1, 7) * 16;
      tk = $urandom_range(0, 2) != 0;
      ph = m_hitf(1, a);
      cyc("rnd", $urandom_range(0, 4) != 0,
          $urandom_range(0, 63),
          $urandom_range(0, 3) != 0, a, tk, tg,
          ph, m_tgtf(a),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 30) == 0,
          $urandom_range(0, 20) == 0);
    end

    // asynchronous reset in the middle of an update
    cyc("t7a", 1, 'h13, 1, 'h13, 1, 'h60, 0, 0);
    en = 1; pc = 16'h0013; upd_valid = 1;
    upd_pc = 16'h0013; upd_taken = 1;
    upd_target = 16'h0060; stall = 0;
    flush = 0; cnt_clr = 0;
    #2;
    rst_n = 0;
    m_reset();
    #1;
    chk("t7_hit", hit, 0);
    chk_stats("t7");
    @(negedge clk);
    upd_valid = 0;
    rst_n = 1;
    idle("t7b", 'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters and built-in prediction statistics.
- Next-generation predictor for the 5-stage CPU pipeline.
- Looked up combinationally by the fetch-stage PC (pre-mux); trained from the EX stage when a branch/jump resolves.
- Prediction stat pulses and saturating stat counters are exposed for the memory-mapped stats/LED logic.

Parameters:
ADDR_W, 16, PC/target width in bits
IDX_W, 4, index bits; table depth = 2**IDX_W entries; TAG_W = ADDR_W-IDX_W (derived localparam)
CNT_W, 16, width of each statistics counter
INIT_CTR, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
en  in  1  prediction enable (SW[0]); 0 forces hit=0
pc  in  ADDR_W  fetch PC (pre-mux) for lookup
hit  out  1  predict taken this cycle
target_pc  out  ADDR_W  predicted target, valid when hit=1
stall  in  1  pipeline stall (stall_IM_ID); blocks update acceptance
upd_valid  in  1  resolved branch/jump in EX
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_taken  in  1  actual outcome (flow change)
upd_target  in  ADDR_W  actual target
upd_pred_hit  in  1  hit value carried down the pipe with this instruction (btb_hit_ID_EX)
upd_pred_target  in  ADDR_W  target predicted for this instruction
flush  in  1  synchronous invalidate of all entries
cnt_clr  in  1  synchronous clear of stat counters
inc_br_cnt  out  1  one-cycle pulse per accepted update
inc_hit_cnt  out  1  pulse when the prediction was correct
inc_mispr_cnt  out  1  pulse when the prediction was wrong
br_cnt, hit_cnt, mispr_cnt  out  CNT_W each  saturating statistics

Behaviour:
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[2]. Index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W].
- Lookup is combinational, zero latency: hit = en & valid & tag match & ctr[1]; target_pc = entry target (0 when no tag match).
- Update accepted = upd_valid & ~stall. Table writes and stat updates occur on the clk edge only.
- Taken, tag match: ctr saturating-increments (11 stays 11); target overwritten with upd_target.
- Taken, miss or invalid: allocate/replace the entry; valid=1, tag, target=upd_target, ctr=INIT_CTR.
- Not taken, tag match: ctr saturating-decrements (00 stays 00); entry stays valid; target unchanged.
- Not taken, miss: no write.
- Training continues when en=0. Statistics also continue; upd_pred_hit is 0 in that case.
- Correct prediction = (upd_pred_hit==upd_taken) & (~upd_taken | upd_pred_target==upd_target). Mispredict = accepted & ~correct.
- Stat pulses are registered: asserted exactly the cycle after the accepting edge, for one cycle. inc_hit_cnt and inc_mispr_cnt are mutually exclusive; each pulse coincides with inc_br_cnt.
- Stat counters increment in the same edge as the pulse is set and saturate at all-ones.
- cnt_clr zeroes the counters. cnt_clr has priority over a same-cycle increment; the pulse still fires.
- Lookup and update on the same index in the same cycle: lookup returns pre-update contents. The new contents are visible the following cycle.
- flush: all valid bits cleared at the edge. It has priority over a same-cycle update, which is dropped from the table but still counted in stats.
- Reset (async, any time, including mid-update): all valid=0, ctr=00, counters 0, pulses 0. hit=0 immediately while rst_n=0.
- Targets and tags need no reset; only valid gates them.

Decomposition:
- Shared package (bpred_pkg): localparams for counter encodings SNT=00, WNT=01, WT=10, ST=11; entry struct/field widths; saturating inc/dec functions.
- Sub-module bpred_stats: three pulse registers plus saturating CNT_W counters with clear; instantiated once.
- Table storage stays in bpred_btb (regs, not RAM, for combinational read).

Test Plan:
1. Reset, en=1, pc=0x0013 -> hit=0, all counters 0; then upd at pc=0x0013 taken target=0x0040, pred_hit=0 -> next cycle inc_br_cnt=1, inc_mispr_cnt=1; lookup pc=0x0013 gives hit=1, target_pc=0x0040.
2. Same branch taken twice more with pred_hit=1, target 0x0040 -> ctr reaches 11, two inc_hit_cnt pulses; four not-taken updates -> hit drops after the 2nd (ctr 01), ctr floors at 00, entry still valid.
3. Alias: pc=0x0023 taken target=0x0100 evicts 0x0013 (index 3) -> lookup 0x0013 hit=0, lookup 0x0023 hit=1, target_pc=0x0100.
4. Same-cycle lookup and update on index 5 -> hit reflects old entry that cycle and new entry next cycle; stall=1 with upd_valid=1 -> no table change, no pulses.
5. Taken with pred_hit=1, upd_pred_target=0x0040, actual 0x0044 -> inc_mispr_cnt=1, target updated to 0x0044; en=0 -> hit=0 while training continues.
6. Preload hit_cnt to saturation with CNT_W=4 (16 correct updates) -> hit_cnt stays 0xF. cnt_clr with a simultaneous update -> counters 0, pulse still seen. flush -> all lookups miss. rst_n pulled low mid-update -> everything 0 asynchronously.
